ip_id_embedder: RTL and testbench



---
 rtl/ip_id_embedder_pkg.sv | 31 +++
 rtl/ip_id_embedder_ipv4_hdr_tracker.sv | 79 +++++++
 rtl/ip_id_embedder.sv | 74 +++++++
 tb/tb_ip_id_embedder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_id_embedder_pkg.sv
// Shared constants, stream payload type and checksum helper for the IP ID embedder.
package ip_id_embedder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TAG_W  = 2;

  localparam logic [15:0] IPV4_ETHERTYPE  = 16'h0800;
  localparam logic [15:0] VLAN_ETHERTYPE  = 16'h8100;
  localparam logic [15:0] VLAN2_ETHERTYPE = 16'h9100;

  localparam int unsigned ETYPE_WORD_BASE = 3;
  localparam int unsigned MAX_VLAN_TAGS   = 2;
  localparam int unsigned IP_ID_WORD      = 1;
  localparam int unsigned IP_CKSUM_WORD   = 2;

  typedef struct packed {
    logic              valid;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } avst_t;

  // 16-bit one's-complement add with end-around carry
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + 16'(s[16]);
  endfunction

endpackage

// File: rtl/ip_id_embedder_ipv4_hdr_tracker.sv
// Walks Ethernet/VLAN framing on valid words and strobes the IPv4 ID and checksum words.
module ip_id_embedder_ipv4_hdr_tracker
  import ip_id_embedder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        sop,
  input  logic        eop,
  input  logic [15:0] etype,
  input  logic [3:0]  ip_ver,
  input  logic        embed,
  output logic        at_id_word_c,
  output logic        at_cksum_word_c
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ETYPE  = 3'd1;
  localparam logic [2:0] S_HDR0   = 3'd2;
  localparam logic [2:0] S_IDWORD = 3'd3;
  localparam logic [2:0] S_CKSUM  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [TAG_W-1:0] tags, tags_nx;
  logic             is_tag, at_etype;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      tags  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      tags  <= tags_nx;
    end
  end

  // idx holds the index of the next valid word while hunting for the ethertype
  always_comb begin
    state_nx        = state;
    idx_nx          = idx;
    tags_nx         = tags;
    is_tag          = (etype == VLAN_ETHERTYPE) || (etype == VLAN2_ETHERTYPE);
    at_etype        = (idx == IDX_W'(ETYPE_WORD_BASE) + IDX_W'(tags));
    at_id_word_c    = valid && !sop && (state == S_IDWORD);
    at_cksum_word_c = valid && !sop && (state == S_CKSUM);
    if (valid) begin
      if (sop) begin
        state_nx = S_ETYPE;
        idx_nx   = IDX_W'(1);
        tags_nx  = '0;
      end else begin
        case (state)
          S_ETYPE: begin
            idx_nx = idx + IDX_W'(1);
            if (at_etype) begin
              if (!is_tag) begin
                state_nx = (etype == IPV4_ETHERTYPE) ? S_HDR0 : S_DONE;
              end else if (tags == TAG_W'(MAX_VLAN_TAGS)) begin
                state_nx = S_DONE;
              end else begin
                tags_nx = tags + TAG_W'(1);
              end
            end
          end
          S_HDR0:   state_nx = (ip_ver == 4'h4) ? S_IDWORD : S_DONE;
          S_IDWORD: state_nx = embed ? S_CKSUM : S_DONE;
          S_CKSUM:  state_nx = S_DONE;
          default:  state_nx = state;
        endcase
      end
      if (eop) state_nx = S_IDLE;
    end
  end

endmodule

// File: rtl/ip_id_embedder.sv
// Covert-channel transmitter: replaces low IPv4 ID bits with a symbol and patches the
// header checksum incrementally, with a fixed one-cycle pass-through latency.
module ip_id_embedder
  import ip_id_embedder_pkg::*;
#(
  parameter int unsigned SYM_BITS = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  avst_t               in,
  output avst_t               out,
  input  logic                enable,
  input  logic [SYM_BITS-1:0] sym_data,
  input  logic                sym_valid,
  output logic                sym_ready,
  output logic [CNT_W-1:0]    embedded_count,
  output logic                trunc_err
);

  localparam logic [15:0] SYM_MASK = 16'((32'd1 << SYM_BITS) - 32'd1);

  logic        embed, at_id_c, at_cksum_c;
  logic [15:0] id_old_c, id_new_c, cksum_new_c;
  logic [15:0] id_old, id_new;

  ip_id_embedder_ipv4_hdr_tracker u_ipv4_hdr_tracker (
    .clk            (sys_clk),
    .rst_n          (reset_n),
    .valid          (in.valid),
    .sop            (in.sop),
    .eop            (in.eop),
    .etype          (in.data[15:0]),
    .ip_ver         (in.data[31:28]),
    .embed          (embed),
    .at_id_word_c   (at_id_c),
    .at_cksum_word_c(at_cksum_c)
  );

  assign embed     = enable && sym_valid;
  assign sym_ready = at_id_c && embed;

  // RFC 1624: HC' = ~(~HC + ~m + m')
  always_comb begin
    id_old_c    = in.data[31:16];
    id_new_c    = (id_old_c & ~SYM_MASK) | (16'(sym_data) & SYM_MASK);
    cksum_new_c = ~ones_add16(ones_add16(~in.data[15:0], ~id_old), id_new);
  end

  // The checksum word directly follows the ID word, so an eop on an embedded ID word
  // is the only way a packet can end before its checksum is patched.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      out            <= '0;
      id_old         <= '0;
      id_new         <= '0;
      embedded_count <= '0;
      trunc_err      <= 1'b0;
    end else begin
      out <= in;
      if (sym_ready) begin
        out.data[31:16] <= id_new_c;
        id_old          <= id_old_c;
        id_new          <= id_new_c;
        if (in.eop) trunc_err <= 1'b1;
      end
      if (at_cksum_c) begin
        out.data[15:0] <= cksum_new_c;
        if (embedded_count != '1) embedded_count <= embedded_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ip_id_embedder.sv
// Self-checking bench: directed frames plus random IPv4 headers against a frame-level model.
module tb_ip_id_embedder;
  import ip_id_embedder_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  avst_t       in_s, out16, out8;
  logic        enable, sym_valid;
  logic [15:0] sym16;
  logic [7:0]  sym8;
  logic        rdy16, rdy8, trunc16, trunc8;
  logic [15:0] cnt16, cnt8;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  bit exp_trunc = 1'b0;

  logic [31:0] pw[$];
  bit          p_eop;
  logic [31:0] mo[$], exp16[$], exp8[$], cap16[$], cap8[$];
  int          m_rdy;
  bit          m_inc, m_trunc;
  int          rdy_seen;
  int          nt;

  always #5 clk = ~clk;

  ip_id_embedder #(.SYM_BITS(16), .CNT_W(16)) dut16 (
    .sys_clk(clk), .reset_n(rst_n), .in(in_s), .out(out16), .enable(enable),
    .sym_data(sym16), .sym_valid(sym_valid), .sym_ready(rdy16),
    .embedded_count(cnt16), .trunc_err(trunc16));

  ip_id_embedder #(.SYM_BITS(8), .CNT_W(16)) dut8 (
    .sys_clk(clk), .reset_n(rst_n), .in(in_s), .out(out8), .enable(enable),
    .sym_data(sym8), .sym_valid(sym_valid), .sym_ready(rdy8),
    .embedded_count(cnt8), .trunc_err(trunc8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full IPv4 header checksum over five words, checksum field treated as zero
  function automatic logic [15:0] ip_csum(input logic [31:0] h0, input logic [31:0] h1,
                                          input logic [31:0] h2, input logic [31:0] h3,
                                          input logic [31:0] h4);
    int unsigned s;
    s = 32'(h0[31:16]) + 32'(h0[15:0]) + 32'(h1[31:16]) + 32'(h1[15:0]) + 32'(h2[31:16])
      + 32'(h3[31:16]) + 32'(h3[15:0]) + 32'(h4[31:16]) + 32'(h4[15:0]);
    while ((s >> 16) != 0) s = (s & 32'h0000_ffff) + (s >> 16);
    return ~16'(s);
  endfunction

  // Frame-level reference: locate IPv4 behind up to two tags, substitute, recompute
  function automatic void model(input int sb, input logic [15:0] sym, input bit en, input bit sv);
    int          k;
    int          tags;
    int          h;
    bit          ok;
    logic [15:0] mask;
    logic [31:0] w;
    k = 3; tags = 0; ok = 1'b0;
    mo = pw; m_rdy = -1; m_inc = 1'b0; m_trunc = 1'b0;
    while (k < pw.size()) begin
      if (pw[k][15:0] == 16'h8100 || pw[k][15:0] == 16'h9100) begin
        if (tags == 2) break;
        tags++;
        k++;
      end else begin
        ok = (pw[k][15:0] == 16'h0800);
        break;
      end
    end
    h = k + 1;
    if (!ok || !en || !sv || h + 1 >= pw.size()) return;
    if (pw[h][31:28] != 4'h4) return;
    mask = 16'((32'd1 << sb) - 32'd1);
    w = mo[h+1];
    w[31:16] = (pw[h+1][31:16] & ~mask) | (sym & mask);
    mo[h+1] = w;
    m_rdy = h + 1;
    if (h + 2 >= pw.size()) begin
      m_trunc = p_eop;
      return;
    end
    w = mo[h+2];
    w[15:0] = ip_csum(mo[h], mo[h+1], mo[h+2], mo[h+3], mo[h+4]);
    mo[h+2] = w;
    m_inc = 1'b1;
  endfunction

  task automatic start_frame();
    pw.delete();
    for (int i = 0; i < 3; i++) pw.push_back($urandom);
  endtask

  task automatic push_etype(input logic [15:0] e);
    pw.push_back({16'($urandom), e});
  endtask

  task automatic push_dir_hdr(input int nwords);
    logic [31:0] d[5];
    d = '{32'h4500_0073, 32'h0000_4000, 32'h4011_b861, 32'hc0a8_0001, 32'hc0a8_00c7};
    for (int i = 0; i < nwords; i++) pw.push_back(d[i]);
  endtask

  task automatic push_hdr(input logic [15:0] id);
    logic [31:0] h[5];
    h[0] = {8'h45, 8'($urandom), 16'($urandom)};
    h[1] = {id, 16'($urandom)};
    h[2] = {16'($urandom), 16'h0000};
    h[3] = $urandom;
    h[4] = $urandom;
    h[2][15:0] = ip_csum(h[0], h[1], h[2], h[3], h[4]);
    for (int i = 0; i < 5; i++) pw.push_back(h[i]);
  endtask

  task automatic push_payload(input int n);
    for (int i = 0; i < n; i++) pw.push_back($urandom);
  endtask

  // Drive pw word by word with random bubbles, checking every output cycle
  task automatic send(input int bub_min, input int bub_max, input bit rst_at_id);
    int   nb;
    logic e_eop;
    model(16, sym16, enable, sym_valid);
    exp16 = mo;
    model(8, {8'h00, sym8}, enable, sym_valid);
    exp8 = mo;
    cap16.delete(); cap8.delete(); rdy_seen = 0;
    for (int i = 0; i < pw.size(); i++) begin
      @(negedge clk);
      e_eop      = p_eop && (i == pw.size() - 1);
      in_s.valid = 1'b1;
      in_s.sop   = (i == 0);
      in_s.eop   = e_eop;
      in_s.data  = pw[i];
      #1;
      if (rst_at_id && i == m_rdy) begin
        rst_n = 1'b0;
        #1;
        check("rst_out16", 64'(out16), 64'(0));
        check("rst_out8", 64'(out8), 64'(0));
        check("rst_rdy16", 64'(rdy16), 64'(0));
        check("rst_cnt16", 64'(cnt16), 64'(0));
        check("rst_trunc16", 64'(trunc16), 64'(0));
        @(posedge clk);
        @(negedge clk);
        in_s = '0;
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_trunc = 1'b0;
        return;
      end
      check("sym_ready16", 64'(rdy16), 64'(i == m_rdy));
      check("sym_ready8", 64'(rdy8), 64'(i == m_rdy));
      rdy_seen += int'(rdy16);
      @(posedge clk);
      #1;
      cap16.push_back(out16.data);
      cap8.push_back(out8.data);
      check("out16", 64'(out16), 64'({1'b1, i == 0, e_eop, exp16[i]}));
      check("out8", 64'(out8), 64'({1'b1, i == 0, e_eop, exp8[i]}));
      nb = (i == pw.size() - 1) ? 1 : $urandom_range(bub_max, bub_min);
      for (int b = 0; b < nb; b++) begin
        @(negedge clk);
        in_s.valid = 1'b0; in_s.sop = 1'b0; in_s.eop = 1'b0; in_s.data = $urandom;
        #1;
        check("bubble_rdy16", 64'(rdy16), 64'(0));
        @(posedge clk);
        #1;
        check("bubble_valid16", 64'(out16.valid), 64'(0));
        check("bubble_valid8", 64'(out8.valid), 64'(0));
      end
    end
    if (m_inc && exp_cnt < 16'hffff) exp_cnt++;
    exp_trunc |= m_trunc;
    check("count16", 64'(cnt16), 64'(exp_cnt));
    check("count8", 64'(cnt8), 64'(exp_cnt));
    check("trunc16", 64'(trunc16), 64'(exp_trunc));
    check("trunc8", 64'(trunc8), 64'(exp_trunc));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_s = '0; enable = 1'b0; sym_valid = 1'b0; sym16 = '0; sym8 = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_out16", 64'(out16), 64'(0));
    check("reset_rdy16", 64'(rdy16), 64'(0));
    check("reset_cnt16", 64'(cnt16), 64'(0));
    check("reset_trunc16", 64'(trunc16), 64'(0));
    check("reset_out8", 64'(out8), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Untagged reference header
    enable = 1'b1; sym_valid = 1'b1; sym16 = 16'h1234; sym8 = 8'h34;
    start_frame(); push_etype(16'h0800); push_dir_hdr(5); push_payload(2); p_eop = 1'b1;
    send(0, 0, 1'b0);
    check("untag_id", 64'(cap16[5][31:16]), 64'(16'h1234));
    check("untag_cksum", 64'(cap16[6][15:0]), 64'(16'ha62d));
    check("untag_pulses", 64'(rdy_seen), 64'(1));
    check("untag_count", 64'(cnt16), 64'(1));

    // One tag, bubbles everywhere
    start_frame(); push_etype(16'h8100); push_etype(16'h0800); push_dir_hdr(5); p_eop = 1'b1;
    send(1, 2, 1'b0);
    check("tag1_id", 64'(cap16[6][31:16]), 64'(16'h1234));
    check("tag1_cksum", 64'(cap16[7][15:0]), 64'(16'ha62d));

    // Two tags
    start_frame(); push_etype(16'h9100); push_etype(16'h8100); push_etype(16'h0800);
    push_dir_hdr(5); p_eop = 1'b1;
    send(1, 2, 1'b0);
    check("tag2_id", 64'(cap16[7][31:16]), 64'(16'h1234));
    check("tag2_cksum", 64'(cap16[8][15:0]), 64'(16'ha62d));

    // Three tags: not tracked
    start_frame(); push_etype(16'h9100); push_etype(16'h8100); push_etype(16'h8100);
    push_etype(16'h0800); push_dir_hdr(5); p_eop = 1'b1;
    send(0, 1, 1'b0);
    check("tag3_pulses", 64'(rdy_seen), 64'(0));

    // IPv6 ethertype, then IPv4 with enable low, then sym_valid low
    start_frame(); push_etype(16'h86DD); push_dir_hdr(5); p_eop = 1'b1;
    send(0, 1, 1'b0);
    check("ipv6_untouched", 64'(cap16[5]), 64'(pw[5]));
    check("ipv6_pulses", 64'(rdy_seen), 64'(0));
    enable = 1'b0;
    start_frame(); push_etype(16'h0800); push_dir_hdr(5); p_eop = 1'b1;
    send(0, 1, 1'b0);
    check("disabled_untouched", 64'(cap16[6]), 64'(pw[6]));
    enable = 1'b1; sym_valid = 1'b0;
    send(0, 1, 1'b0);
    check("novalid_pulses", 64'(rdy_seen), 64'(0));
    sym_valid = 1'b1;

    // Partial substitution on the 8-bit instance
    sym16 = 16'hbeef; sym8 = 8'h5c;
    start_frame(); push_etype(16'h0800); push_hdr(16'hab00); p_eop = 1'b1;
    send(0, 0, 1'b0);
    check("sym8_id", 64'(cap8[5][31:16]), 64'(16'hab5c));

    // eop on the ID word
    start_frame(); push_etype(16'h0800); push_dir_hdr(2); p_eop = 1'b1;
    send(0, 0, 1'b0);
    check("trunc_set", 64'(trunc16), 64'(1));

    // Packet abandoned mid-header by a new sop, then a normal packet
    start_frame(); push_etype(16'h0800); push_dir_hdr(1); p_eop = 1'b0;
    send(0, 0, 1'b0);
    sym16 = 16'h0f0f;
    start_frame(); push_etype(16'h0800); push_hdr(16'($urandom)); p_eop = 1'b1;
    send(0, 0, 1'b0);
    check("after_abort_id", 64'(cap16[5][31:16]), 64'(16'h0f0f));

    // Reset on the ID word, then the same packet again
    sym16 = 16'h4321;
    start_frame(); push_etype(16'h8100); push_etype(16'h0800); push_hdr(16'h7777);
    p_eop = 1'b1;
    send(0, 1, 1'b1);
    send(0, 1, 1'b0);
    check("post_reset_id", 64'(cap16[6][31:16]), 64'(16'h4321));
    check("post_reset_count", 64'(cnt16), 64'(1));

    // Random headers
    for (int p = 0; p < 1000; p++) begin
      nt        = $urandom_range(2, 0);
      enable    = ($urandom_range(9, 0) != 0);
      sym_valid = ($urandom_range(9, 0) != 0);
      sym16     = 16'($urandom);
      sym8      = 8'($urandom);
      start_frame();
      if (nt == 2) push_etype(16'h9100);
      if (nt >= 1) push_etype(16'h8100);
      push_etype(($urandom_range(9, 0) == 0) ? 16'h86DD : 16'h0800);
      push_hdr(16'($urandom));
      push_payload($urandom_range(3, 0));
      p_eop = 1'b1;
      send(0, 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
